i2c_arbiter: RTL and testbench

- Shares the single I2C register-write engine (7-bit chip address fixed inside the engine, 16-bit reg/data word per transaction) between several requesters.
- Typical requesters: the power-up codec initializer, runtime volume/sample-rate control, and a debug port.
- Grants one requester at a time, round-robin, and issues one start pulse per transaction. It returns a done pulse to the owner when the engine reports finished.
- Sits between the requesters and the I2C engine inside the audio top level.

---
 rtl/i2c_arbiter.sv | 121 ++++++++++++
 tb/tb_i2c_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one I2C register-write engine among NUM_REQ requesters.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_reg_data,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_done,
  output logic                      o_error,
  output logic                      o_busy,
  output logic                      o_i2c_start,
  output logic [DATA_W-1:0]         o_i2c_reg_data,
  input  logic                      i_i2c_finished
);
  localparam int IDX_W = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("i2c_arbiter: illegal parameter value");
  end
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t              state;
  logic [IDX_W-1:0]    ptr, win;
  logic [DATA_W-1:0]   win_data;
  assign o_busy = (state != S_IDLE);
  // Lowest index above ptr wins; otherwise wrap to lowest index at or below ptr.
  always_comb begin
    win = ptr;
    win_data = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (i_req[i] && IDX_W'(i) <= ptr) begin
        win = IDX_W'(i);
        win_data = i_reg_data[i*DATA_W +: DATA_W];
      end
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (i_req[i] && IDX_W'(i) > ptr) begin
        win = IDX_W'(i);
        win_data = i_reg_data[i*DATA_W +: DATA_W];
      end
  end
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             tmo;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      ptr            <= IDX_W'(NUM_REQ-1);
      o_grant        <= '0;
      o_done         <= '0;
      o_error        <= 1'b0;
      o_i2c_start    <= 1'b0;
      o_i2c_reg_data <= '0;
      cnt            <= '0;
      tmo            <= 1'b0;
    end else begin
      o_done      <= '0;
      o_error     <= 1'b0;
      o_i2c_start <= 1'b0;
      case (state)
        S_IDLE: if (|i_req) begin
          state          <= S_WAIT;
          o_grant        <= NUM_REQ'(1) << win;
          o_i2c_reg_data <= win_data;
          o_i2c_start    <= 1'b1;
          ptr            <= win;
          cnt            <= '0;
          tmo            <= 1'b0;
        end
        // finished on the timeout cycle takes priority, so no error is flagged
        S_WAIT: if (i_i2c_finished) state <= S_DONE;
          else if (cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
            state <= S_DONE;
            tmo   <= 1'b1;
          end else cnt <= cnt + 1'b1;
        S_DONE: begin
          o_done  <= o_grant;
          o_error <= tmo;
          o_grant <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign o_error = 1'b0;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      ptr            <= IDX_W'(NUM_REQ-1);
      o_grant        <= '0;
      o_done         <= '0;
      o_i2c_start    <= 1'b0;
      o_i2c_reg_data <= '0;
    end else begin
      o_done      <= '0;
      o_i2c_start <= 1'b0;
      case (state)
        S_IDLE: if (|i_req) begin
          state          <= S_WAIT;
          o_grant        <= NUM_REQ'(1) << win;
          o_i2c_reg_data <= win_data;
          o_i2c_start    <= 1'b1;
          ptr            <= win;
        end
        S_WAIT: if (i_i2c_finished) state <= S_DONE;
        S_DONE: begin
          o_done  <= o_grant;
          o_grant <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: scoreboard bench for i2c_arbiter (2 requesters, 16-bit words, timeout 20).
module tb_i2c_arbiter;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [1:0]  i_req = '0;
  logic [15:0] w0 = '0, w1 = '0;
  logic [1:0]  o_grant, o_done;
  logic        o_error, o_busy, o_i2c_start;
  logic [15:0] o_i2c_reg_data;
  logic        i_i2c_finished = 1'b0;
  int          n_cmp = 0, n_bad = 0;
  logic [17:0] exp_s[$];
  logic [2:0]  exp_d[$];

  i2c_arbiter #(.NUM_REQ(2), .DATA_W(16), .TIMEOUT_CYCLES(20)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_reg_data({w1, w0}),
    .o_grant(o_grant), .o_done(o_done), .o_error(o_error), .o_busy(o_busy),
    .o_i2c_start(o_i2c_start), .o_i2c_reg_data(o_i2c_reg_data),
    .i_i2c_finished(i_i2c_finished)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every start and done pulse must match the next queued expectation
  always @(negedge i_clk) begin
    logic [17:0] es;
    logic [2:0]  ed;
    if (o_i2c_start) begin
      if (exp_s.size() == 0) chk("unexpected_start", 32'(o_grant), 32'h0);
      else begin
        es = exp_s.pop_front();
        chk("start_grant", 32'(o_grant), 32'(es[17:16]));
        chk("start_data", 32'(o_i2c_reg_data), 32'(es[15:0]));
      end
    end
    if (|o_done) begin
      if (exp_d.size() == 0) chk("unexpected_done", 32'(o_done), 32'h0);
      else begin
        ed = exp_d.pop_front();
        chk("done_vec", 32'(o_done), 32'(ed[2:1]));
        chk("done_err", 32'(o_error), 32'(ed[0]));
      end
    end
  end

  task automatic wait_sig(input string name, input bit is_done, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge i_clk);
      if (is_done ? |o_done : o_i2c_start) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out after %0d cycles, expected a pulse", name, lim);
  endtask

  task automatic pulse_fin();
    i_i2c_finished = 1'b1;
    @(negedge i_clk);
    i_i2c_finished = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge i_clk);
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_error", 32'(o_error), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_start", 32'(o_i2c_start), 0);
    chk("rst_data", 32'(o_i2c_reg_data), 0);
    i_rst_n = 1'b1;
    // 1: single request, latency checks
    @(negedge i_clk);
    w0 = 16'h1E00; w1 = 16'hDEAD;
    exp_s.push_back({2'b01, 16'h1E00});
    exp_d.push_back({2'b01, 1'b0});
    i_req = 2'b01;
    @(negedge i_clk);
    chk("t1_start_lat", 32'(o_i2c_start), 1);
    chk("t1_busy", 32'(o_busy), 1);
    repeat (9) @(negedge i_clk);
    pulse_fin();
    chk("t1_no_early_done", 32'(o_done), 0);
    @(negedge i_clk);
    chk("t1_done_lat", 32'(o_done), 2'b01);
    i_req = 2'b00;
    @(negedge i_clk);
    chk("t1_idle", 32'(o_busy), 0);
    chk("t1_data_held", 32'(o_i2c_reg_data), 16'h1E00);
    // 2: both held, alternating service after a fresh reset
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    w0 = 16'h0815; w1 = 16'h0A00;
    for (int i = 0; i < 4; i++) begin
      exp_s.push_back(i[0] ? {2'b10, 16'h0A00} : {2'b01, 16'h0815});
      exp_d.push_back(i[0] ? {2'b10, 1'b0} : {2'b01, 1'b0});
    end
    i_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_sig("t2_start", 1'b0, 10);
      repeat (5) @(negedge i_clk);
      pulse_fin();
      wait_sig("t2_done", 1'b1, 10);
    end
    i_req = 2'b00;
    @(negedge i_clk);
    chk("t2_data_held", 32'(o_i2c_reg_data), 16'h0A00);
    // 3: owner withdraws during the wait; still completes, no restart
    exp_s.push_back({2'b01, 16'h0815});
    exp_d.push_back({2'b01, 1'b0});
    i_req = 2'b01;
    wait_sig("t3_start", 1'b0, 10);
    @(negedge i_clk);
    i_req = 2'b00;
    repeat (3) @(negedge i_clk);
    pulse_fin();
    wait_sig("t3_done", 1'b1, 10);
    repeat (5) @(negedge i_clk);
    chk("t3_idle", 32'(o_busy), 0);
    // 4: spurious finished in idle, and a wide finished spilling over S_DONE
    i_i2c_finished = 1'b1;
    repeat (2) @(negedge i_clk);
    i_i2c_finished = 1'b0;
    chk("t4_idle_busy", 32'(o_busy), 0);
    chk("t4_idle_done", 32'(o_done), 0);
    exp_s.push_back({2'b10, 16'h0A00});
    exp_d.push_back({2'b10, 1'b0});
    i_req = 2'b10;
    wait_sig("t4_start", 1'b0, 10);
    repeat (3) @(negedge i_clk);
    i_i2c_finished = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("t4_done", 32'(o_done), 2'b10);
    i_req = 2'b00;
    @(negedge i_clk);
    i_i2c_finished = 1'b0;
    chk("t4_single_done", 32'(o_done), 0);
    @(negedge i_clk);
    chk("t4_back_idle", 32'(o_busy), 0);
    // 5: async reset mid-wait
    w0 = 16'h1234; w1 = 16'h5678;
    exp_s.push_back({2'b01, 16'h1234});
    i_req = 2'b01;
    wait_sig("t5_start", 1'b0, 10);
    repeat (2) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(o_grant), 0);
    chk("t5_rst_busy", 32'(o_busy), 0);
    chk("t5_rst_data", 32'(o_i2c_reg_data), 0);
    chk("t5_rst_done", 32'(o_done), 0);
    @(negedge i_clk);
    exp_s.push_back({2'b01, 16'h1234});
    exp_d.push_back({2'b01, 1'b0});
    i_req = 2'b11;
    i_rst_n = 1'b1;
    wait_sig("t5_start2", 1'b0, 10);
    repeat (2) @(negedge i_clk);
    pulse_fin();
    wait_sig("t5_done", 1'b1, 10);
    i_req = 2'b00;
    @(negedge i_clk);
    // 6: engine never finishes
`ifdef I2C_ARB_TIMEOUT_EN
    exp_s.push_back({2'b10, 16'h5678});
    exp_d.push_back({2'b10, 1'b1});
    exp_s.push_back({2'b01, 16'h1234});
    exp_d.push_back({2'b01, 1'b0});
    i_req = 2'b11;
    wait_sig("t6_start", 1'b0, 10);
    wait_sig("t6_timeout", 1'b1, 40);
    chk("t6_error", 32'(o_error), 1);
    i_req = 2'b01;
    wait_sig("t6_next_start", 1'b0, 10);
    repeat (2) @(negedge i_clk);
    pulse_fin();
    wait_sig("t6_next_done", 1'b1, 10);
    i_req = 2'b00;
`else
    exp_s.push_back({2'b01, 16'h1234});
    exp_d.push_back({2'b01, 1'b0});
    i_req = 2'b01;
    wait_sig("t6_start", 1'b0, 10);
    for (int i = 0; i < 60; i++) begin
      @(negedge i_clk);
      chk("t6_busy_hold", 32'(o_busy), 1);
      chk("t6_no_error", 32'(o_error), 0);
    end
    pulse_fin();
    wait_sig("t6_done", 1'b1, 10);
    i_req = 2'b00;
`endif
    repeat (3) @(negedge i_clk);
    chk("end_start_queue", 32'(exp_s.size()), 0);
    chk("end_done_queue", 32'(exp_d.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
